// File: rtl/taxi_axis_if.sv
// taxi_axis_if: AXI4-Stream bundle with source, sink and monitor views.

interface taxi_axis_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned KEEP_W = (DATA_W + 7) / 8,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned DEST_W = 8,
    parameter int unsigned USER_W = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport snk (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
    modport mon (input tdata, tkeep, tvalid, tready, tlast, tid, tdest, tuser);
endinterface

// File: rtl/taxi_stats_accum.sv
// taxi_stats_accum: per-ID statistics counters accumulated from an AXI-Stream
// increment stream, with a pipelined, non-destructive read port.
// Optional string table is enabled by defining TAXI_STATS_STR_EN.

module taxi_stats_accum #(
    parameter int unsigned STAT_COUNT = 32,
    parameter int unsigned STAT_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    taxi_axis_if.snk                      s_axis_stat,
    input  logic [$clog2(STAT_COUNT)-1:0] rd_req_addr,
    input  logic                          rd_req_str,
    input  logic                          rd_req_valid,
    output logic                          rd_req_ready,
    output logic [STAT_W-1:0]             rd_resp_data,
    output logic                          rd_resp_valid
);
    localparam int unsigned DATA_W = s_axis_stat.DATA_W;
    localparam int unsigned ID_W   = s_axis_stat.ID_W;
    localparam int unsigned ADDR_W = $clog2(STAT_COUNT);
    localparam int unsigned CMP_W  = (ID_W > 32) ? ID_W : 32;

    // Elaboration-time parameter sanity
    if (STAT_W < DATA_W) begin : g_chk_stat_w
        $fatal(1, "taxi_stats_accum: STAT_W must be >= DATA_W");
    end
    if ((64'(1) << ID_W) < 64'(STAT_COUNT)) begin : g_chk_id_w
        $fatal(1, "taxi_stats_accum: ID_W too narrow for STAT_COUNT");
    end

    typedef enum logic [0:0] {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] init_addr;

    logic [STAT_W-1:0] cnt_mem [STAT_COUNT];
    logic              cnt_we;
    logic [ADDR_W-1:0] cnt_waddr;
    logic [STAT_W-1:0] cnt_wdata;

    logic              beat_acc;
    logic              rd_acc;
    logic              id_in_range;

    // Stage 1: registered beat (memory update) and read request (memory read)
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data;
    logic              r1_valid;
    logic              r1_str;
    logic [ADDR_W-1:0] r1_addr;
    logic [STAT_W-1:0] rd_data_c;

    logic unused_ok;
    assign unused_ok = ^{s_axis_stat.tkeep, s_axis_stat.tlast, s_axis_stat.tdest, s_axis_stat.tuser};

    // Handshakes: reads win over the stream while running
    assign rd_req_ready       = (state == ST_RUN);
    assign s_axis_stat.tready = (state == ST_RUN) && !rd_req_valid;
    assign beat_acc           = s_axis_stat.tvalid && s_axis_stat.tready;
    assign rd_acc             = rd_req_valid && rd_req_ready;
    assign id_in_range        = CMP_W'(s_axis_stat.tid) < CMP_W'(STAT_COUNT);

`ifdef TAXI_STATS_STR_EN
    localparam int unsigned STR_W     = 12;
    localparam int unsigned STR_DEPTH = 2 ** ADDR_W;

    if (DATA_W < 16 || ADDR_W < 3 || STAT_W < STR_W) begin : g_chk_str
        $fatal(1, "taxi_stats_accum: string table needs DATA_W>=16, ADDR_W>=3, STAT_W>=12");
    end

    logic [STR_W-1:0]  str_mem [STR_DEPTH];
    logic              s1_str_valid;
    logic              str_in_range;
    logic [ADDR_W-1:0] str_addr;

    // String entry index is {tid, prfx, ptr}; entries outside the table are dropped
    assign str_in_range = (s_axis_stat.tid >> (ADDR_W - 3)) == '0;
    assign str_addr     = ADDR_W'({s_axis_stat.tid, s_axis_stat.tdata[2:0]});

    // String table write, one cycle after acceptance; never cleared by the sweep
    always_ff @(posedge clk) begin
        if (s1_str_valid && !rst) begin
            str_mem[s1_addr] <= s1_data[15:4];
        end
    end
`endif

    // Single counter write port: zero sweep during INIT, accumulate during RUN
    always_comb begin
        cnt_we    = 1'b0;
        cnt_waddr = s1_addr;
        cnt_wdata = cnt_mem[s1_addr] + STAT_W'(s1_data);
        if (!rst) begin
            if (state == ST_INIT) begin
                cnt_we    = 1'b1;
                cnt_waddr = init_addr;
                cnt_wdata = '0;
            end else if (s1_valid) begin
                cnt_we = 1'b1;
            end
        end
    end

    // Counter storage
    always_ff @(posedge clk) begin
        if (cnt_we) begin
            cnt_mem[cnt_waddr] <= cnt_wdata;
        end
    end

    // Read data select for the stage-1 read
    always_comb begin
        rd_data_c = cnt_mem[r1_addr];
        if (r1_str) begin
`ifdef TAXI_STATS_STR_EN
            rd_data_c = STAT_W'(str_mem[r1_addr]);
`else
            rd_data_c = '0;
`endif
        end
    end

    // Stage-1 payload capture (no reset needed, qualified by valids)
    always_ff @(posedge clk) begin
`ifdef TAXI_STATS_STR_EN
        s1_addr <= s_axis_stat.tuser[0] ? str_addr : ADDR_W'(s_axis_stat.tid);
`else
        s1_addr <= ADDR_W'(s_axis_stat.tid);
`endif
        s1_data <= s_axis_stat.tdata;
        r1_addr <= rd_req_addr;
        r1_str  <= rd_req_str;
    end

    // State machine, pipeline valids and registered read response
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_INIT;
            init_addr     <= '0;
            s1_valid      <= 1'b0;
            r1_valid      <= 1'b0;
            rd_resp_valid <= 1'b0;
            rd_resp_data  <= '0;
`ifdef TAXI_STATS_STR_EN
            s1_str_valid  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_INIT: begin
                    init_addr <= init_addr + ADDR_W'(1);
                    if (init_addr == ADDR_W'(STAT_COUNT - 1)) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase

            s1_valid      <= beat_acc && !s_axis_stat.tuser[0] && id_in_range;
`ifdef TAXI_STATS_STR_EN
            s1_str_valid  <= beat_acc && s_axis_stat.tuser[0] && str_in_range;
`endif
            r1_valid      <= rd_acc;
            rd_resp_valid <= r1_valid;
            if (r1_valid) begin
                rd_resp_data <= rd_data_c;
            end
        end
    end

endmodule

// File: tb/tb_taxi_stats_accum.sv
// tb_taxi_stats_accum: directed-vector bench for taxi_stats_accum.

module tb_taxi_stats_accum;
    localparam int unsigned STAT_COUNT = 32;
    localparam int unsigned STAT_W     = 32;
    localparam int unsigned ADDR_W     = $clog2(STAT_COUNT);

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_req_str;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [STAT_W-1:0] rd_resp_data;
    logic              rd_resp_valid;

    int n_vec  = 0;
    int n_miss = 0;
    logic [STAT_W-1:0] model [STAT_COUNT];

    taxi_axis_if #(.DATA_W(32), .ID_W(8), .DEST_W(8), .USER_W(1)) stat_if ();

    taxi_stats_accum #(
        .STAT_COUNT(STAT_COUNT),
        .STAT_W(STAT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_stat(stat_if),
        .rd_req_addr(rd_req_addr),
        .rd_req_str(rd_req_str),
        .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready),
        .rd_resp_data(rd_resp_data),
        .rd_resp_valid(rd_resp_valid)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic stream_idle;
        stat_if.tvalid = 1'b0;
        stat_if.tuser  = 1'b0;
    endtask

    // Present one beat and hold it until accepted; cycles = -1 if never accepted
    task automatic drive_beat(input int id, input logic [31:0] data, input logic user, output int cycles);
        logic acc;
        stat_if.tvalid = 1'b1;
        stat_if.tid    = 8'(id);
        stat_if.tdata  = data;
        stat_if.tuser  = user;
        acc    = 1'b0;
        cycles = -1;
        for (int i = 1; i <= 50 && !acc; i++) begin
            @(negedge clk);
            acc = stat_if.tready;
            if (acc) cycles = i;
            step();
        end
    endtask

    // Single read; lat_ok is set only if the response arrives exactly two cycles after acceptance
    task automatic do_read(input int addr, input logic str, output logic [STAT_W-1:0] data, output logic lat_ok);
        rd_req_addr  = ADDR_W'(addr);
        rd_req_str   = str;
        rd_req_valid = 1'b1;
        @(negedge clk);
        lat_ok = rd_req_ready;
        step();
        rd_req_valid = 1'b0;
        @(negedge clk);
        lat_ok = lat_ok && !rd_resp_valid;
        @(negedge clk);
        lat_ok = lat_ok && rd_resp_valid;
        data   = rd_resp_data;
        step();
    endtask

    task automatic test_reset;
        logic [STAT_W-1:0] d;
        logic ok;
        rst = 1'b1;
        rd_req_valid = 1'b0;
        rd_req_addr  = '0;
        rd_req_str   = 1'b0;
        stat_if.tkeep = '1;
        stat_if.tlast = 1'b1;
        stat_if.tdest = '0;
        stat_if.tid   = '0;
        stat_if.tdata = '0;
        stream_idle();
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (stat_if.tready !== 1'b0 || rd_req_ready !== 1'b0 || rd_resp_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL init_handshake: tready=%b rd_req_ready=%b rd_resp_valid=%b required 0 0 0",
                     stat_if.tready, rd_req_ready, rd_resp_valid);
        end
        n_vec++;
        if (rd_resp_data !== '0) begin
            n_miss++;
            $display("FAIL reset_resp_data: got %h required 0", rd_resp_data);
        end
        // Reset again mid-sweep; the sweep must restart from zero
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= int'(STAT_COUNT); k++) begin
            step();
            if (k == int'(STAT_COUNT) - 1) begin
                n_vec++;
                if (stat_if.tready !== 1'b0 || rd_req_ready !== 1'b0) begin
                    n_miss++;
                    $display("FAIL sweep_early: tready=%b rd_req_ready=%b at cycle %0d required 0",
                             stat_if.tready, rd_req_ready, k);
                end
            end
            if (k == int'(STAT_COUNT)) begin
                n_vec++;
                if (stat_if.tready !== 1'b1 || rd_req_ready !== 1'b1) begin
                    n_miss++;
                    $display("FAIL sweep_done: tready=%b rd_req_ready=%b at cycle %0d required 1",
                             stat_if.tready, rd_req_ready, k);
                end
            end
        end
        for (int a = 0; a < int'(STAT_COUNT); a++) begin
            model[a] = '0;
            do_read(a, 1'b0, d, ok);
            n_vec++;
            if (d !== '0 || !ok) begin
                n_miss++;
                $display("FAIL cleared_cnt[%0d]: got %h lat_ok=%b required 0 lat_ok=1", a, d, ok);
            end
        end
    endtask

    task automatic test_accumulate;
        logic [STAT_W-1:0] d;
        logic ok;
        int cyc;
        int total;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            drive_beat(3, 32'd5, 1'b0, cyc);
            total += cyc;
        end
        stream_idle();
        model[3] = 32'd20;
        n_vec++;
        if (total != 4) begin
            n_miss++;
            $display("FAIL b2b_no_stall: took %0d cycles for 4 beats required 4", total);
        end
        do_read(3, 1'b0, d, ok);
        n_vec++;
        if (d !== 32'd20) begin
            n_miss++;
            $display("FAIL accum_cnt3: got %0d required 20", d);
        end
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL read_latency: response not exactly 2 cycles after acceptance");
        end
        @(negedge clk);
        n_vec++;
        if (rd_resp_valid !== 1'b0 || rd_resp_data !== 32'd20) begin
            n_miss++;
            $display("FAIL resp_hold: valid=%b data=%0d required valid=0 data=20", rd_resp_valid, rd_resp_data);
        end
        step();
        drive_beat(3, 32'd0, 1'b0, cyc);
        stream_idle();
        do_read(3, 1'b0, d, ok);
        n_vec++;
        if (d !== 32'd20 || cyc != 1) begin
            n_miss++;
            $display("FAIL zero_incr: got %0d accept_cycles=%0d required 20 and 1", d, cyc);
        end
    endtask

    task automatic test_wrap;
        logic [STAT_W-1:0] d;
        logic ok;
        int cyc;
        drive_beat(7, 32'hFFFF_FFFE, 1'b0, cyc);
        drive_beat(7, 32'd3, 1'b0, cyc);
        stream_idle();
        model[7] = 32'h0000_0001;
        do_read(7, 1'b0, d, ok);
        n_vec++;
        if (d !== 32'h0000_0001 || !ok) begin
            n_miss++;
            $display("FAIL wrap_cnt7: got %h lat_ok=%b required 00000001 lat_ok=1", d, ok);
        end
    endtask

    task automatic test_read_priority;
        int            addrs [3]   = '{3, 7, 0};
        logic          exp_v [5]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0]   exp_d [5]   = '{32'd0, 32'd0, 32'd20, 32'd1, 32'd0};
        logic [STAT_W-1:0] d;
        logic ok;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                rd_req_valid = 1'b1;
                rd_req_addr  = ADDR_W'(addrs[c]);
                rd_req_str   = 1'b0;
            end else begin
                rd_req_valid = 1'b0;
            end
            stat_if.tvalid = (c <= 3);
            stat_if.tid    = 8'd4;
            stat_if.tdata  = 32'd1;
            stat_if.tuser  = 1'b0;
            @(negedge clk);
            if (c <= 3) begin
                n_vec++;
                if (stat_if.tready !== (c == 3)) begin
                    n_miss++;
                    $display("FAIL prio_tready[c%0d]: got %b required %b", c, stat_if.tready, (c == 3));
                end
            end
            n_vec++;
            if (rd_resp_valid !== exp_v[c] || (exp_v[c] && rd_resp_data !== exp_d[c])) begin
                n_miss++;
                $display("FAIL prio_resp[c%0d]: valid=%b data=%0d required valid=%b data=%0d",
                         c, rd_resp_valid, rd_resp_data, exp_v[c], exp_d[c]);
            end
            step();
        end
        stream_idle();
        model[4] = 32'd1;
        do_read(4, 1'b0, d, ok);
        n_vec++;
        if (d !== 32'd1 || !ok) begin
            n_miss++;
            $display("FAIL prio_beat_kept: cnt4 got %0d required 1", d);
        end
    endtask

    task automatic test_out_of_range;
        logic [STAT_W-1:0] d;
        logic ok;
        int cyc;
        drive_beat(int'(STAT_COUNT), 32'd9, 1'b0, cyc);
        stream_idle();
        n_vec++;
        if (cyc != 1) begin
            n_miss++;
            $display("FAIL oor_accept: accept_cycles=%0d required 1", cyc);
        end
        for (int a = 0; a < int'(STAT_COUNT); a++) begin
            do_read(a, 1'b0, d, ok);
            n_vec++;
            if (d !== model[a] || !ok) begin
                n_miss++;
                $display("FAIL oor_cnt[%0d]: got %h required %h", a, d, model[a]);
            end
        end
    endtask

    task automatic test_string;
        logic [STAT_W-1:0] d;
        logic [STAT_W-1:0] exp;
        logic ok;
        int cyc;
`ifdef TAXI_STATS_STR_EN
        exp = 32'h0000_0ABC;
`else
        exp = 32'h0000_0000;
`endif
        drive_beat(2, 32'h0000_ABC5, 1'b1, cyc);
        stream_idle();
        n_vec++;
        if (cyc != 1) begin
            n_miss++;
            $display("FAIL str_accept: accept_cycles=%0d required 1", cyc);
        end
        do_read((2 << 3) | 5, 1'b1, d, ok);
        n_vec++;
        if (d !== exp || !ok) begin
            n_miss++;
            $display("FAIL str_read: got %h lat_ok=%b required %h lat_ok=1", d, ok, exp);
        end
        do_read(2, 1'b0, d, ok);
        n_vec++;
        if (d !== model[2]) begin
            n_miss++;
            $display("FAIL str_cnt2_untouched: got %h required %h", d, model[2]);
        end
    endtask

    task automatic test_reset_midflight;
        logic [STAT_W-1:0] d;
        logic ok;
        int k;
        rd_req_addr  = ADDR_W'(3);
        rd_req_str   = 1'b0;
        rd_req_valid = 1'b1;
        step();
        rd_req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (rd_resp_valid !== 1'b0 || rd_resp_data !== '0) begin
            n_miss++;
            $display("FAIL midflight_drop: valid=%b data=%h required 0 0", rd_resp_valid, rd_resp_data);
        end
        k = 0;
        for (int i = 1; i <= 80 && k == 0; i++) begin
            step();
            if (stat_if.tready === 1'b1) k = i;
        end
        n_vec++;
        if (k != int'(STAT_COUNT)) begin
            n_miss++;
            $display("FAIL resweep_len: tready rose after %0d cycles required %0d", k, STAT_COUNT);
        end
        do_read(3, 1'b0, d, ok);
        n_vec++;
        if (d !== '0 || !ok) begin
            n_miss++;
            $display("FAIL resweep_cnt3: got %h required 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_wrap();
        test_read_priority();
        test_out_of_range();
        test_string();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
